serial_cmp_ctrl: RTL

//   Sequencer that shares the single-bit comparator (inputs x,y; output z=1 when x==y)

---
 rtl/serial_cmp_ctrl_if.sv | 27 ++
 rtl/serial_cmp_ctrl.sv | 88 ++++++++
 2 files changed

// File: rtl/serial_cmp_ctrl_if.sv
// Request/result and comparator-lane bundle for serial_cmp_ctrl.
// The slave side is the sequencer; the master side is the requester plus the shared comparator.
interface serial_cmp_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cmp_x;
    logic             cmp_y;
    logic             cmp_z;
    logic             busy;
    logic             done;
    logic             eq;
    logic             gt;
    logic             lt;

    modport slave (
        input  start, a, b, cmp_z,
        output cmp_x, cmp_y, busy, done, eq, gt, lt
    );

    modport master (
        output start, a, b, cmp_z,
        input  cmp_x, cmp_y, busy, done, eq, gt, lt
    );
endinterface

// File: rtl/serial_cmp_ctrl.sv
// Word comparator built from one shared 1-bit equality comparator, walking
// operand bits MSB-first and stopping at the first differing bit.
module serial_cmp_ctrl #(
    parameter int WIDTH = 8
) (
    input logic               clk,
    input logic               rst_n,
    serial_cmp_ctrl_if.slave  bus
);
    localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [IDXW-1:0]  idx;
    logic [IDXW-1:0]  idx_next;

    assign idx_next = idx - IDXW'(1);

    // cmp_x/cmp_y are registered with the bit for the coming RUN cycle, so the
    // comparator sees ra[idx]/rb[idx] without any decode after the flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ra        <= '0;
            rb        <= '0;
            idx       <= '0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.eq    <= 1'b0;
            bus.gt    <= 1'b0;
            bus.lt    <= 1'b0;
            bus.cmp_x <= 1'b0;
            bus.cmp_y <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        ra        <= bus.a;
                        rb        <= bus.b;
                        idx       <= IDXW'(WIDTH - 1);
                        bus.eq    <= 1'b0;
                        bus.gt    <= 1'b0;
                        bus.lt    <= 1'b0;
                        bus.busy  <= 1'b1;
                        bus.cmp_x <= bus.a[WIDTH-1];
                        bus.cmp_y <= bus.b[WIDTH-1];
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (!bus.cmp_z || idx == '0) begin
                        // A mismatching bit decides the order: the side holding the 1 is larger.
                        bus.eq    <= bus.cmp_z;
                        bus.gt    <= ~bus.cmp_z & bus.cmp_x;
                        bus.lt    <= ~bus.cmp_z & ~bus.cmp_x;
                        bus.busy  <= 1'b0;
                        bus.done  <= 1'b1;
                        bus.cmp_x <= 1'b0;
                        bus.cmp_y <= 1'b0;
                        state     <= DONE;
                    end else begin
                        idx       <= idx_next;
                        bus.cmp_x <= ra[idx_next];
                        bus.cmp_y <= rb[idx_next];
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy  <= 1'b0;
                    bus.done  <= 1'b0;
                    bus.cmp_x <= 1'b0;
                    bus.cmp_y <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule
